// File: rtl/isa_io_cycle_initiator_if.sv
// Command/response and ISA bus signals of the I/O cycle initiator.
// The master modport is the initiator's view; slave is the host/bus side.
interface isa_io_cycle_initiator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       isa_ale;
  logic       isa_aen;
  logic [9:0] isa_addr;
  logic       isa_ior;
  logic       isa_iow;
  logic [7:0] isa_data_out;
  logic       isa_data_oe;
  logic [7:0] isa_data_in;
  logic       isa_chrdy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, isa_data_in, isa_chrdy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           isa_ale, isa_aen, isa_addr, isa_ior, isa_iow, isa_data_out, isa_data_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, isa_data_in, isa_chrdy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           isa_ale, isa_aen, isa_addr, isa_ior, isa_iow, isa_data_out, isa_data_oe
  );
endinterface

// File: rtl/isa_io_cycle_initiator.sv
// ISA 8-bit I/O cycle initiator: one command becomes one ALE/IOR#/IOW# bus cycle with CHRDY waits.
// Define ISA_CHRDY_TIMEOUT_EN to abort a strobe held off by CHRDY for TIMEOUT_CYCLES extra cycles.
module isa_io_cycle_initiator #(
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           isa_clk,
  input  logic                           isa_reset,
  isa_io_cycle_initiator_if.master       bus
);

`ifdef ISA_CHRDY_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [7:0] STROBE_LAST   = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ADDR, SETUP, STROBE, HOLD, RESP} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] wait_q, wait_d;
  logic       write_q, write_d;
  logic [7:0] wdata_q, wdata_d;
  logic       timed_out_q, timed_out_d;
  logic       chrdy_meta_q, chrdy_meta_d;
  logic       chrdy_s_q, chrdy_s_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  logic       isa_ale_q, isa_ale_d;
  logic       isa_aen_q, isa_aen_d;
  logic [9:0] isa_addr_q, isa_addr_d;
  logic       isa_ior_q, isa_ior_d;
  logic       isa_iow_q, isa_iow_d;
  logic [7:0] isa_data_out_q, isa_data_out_d;
  logic       isa_data_oe_q, isa_data_oe_d;

  // Every bus output is computed one cycle ahead so all outputs leave flops.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wait_d         = wait_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    timed_out_d    = timed_out_q;
    chrdy_meta_d   = bus.isa_chrdy;
    chrdy_s_d      = chrdy_meta_q;
    cmd_ready_d    = cmd_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_timeout_d  = rsp_timeout_q;
    isa_ale_d      = isa_ale_q;
    isa_aen_d      = isa_aen_q;
    isa_addr_d     = isa_addr_q;
    isa_ior_d      = isa_ior_q;
    isa_iow_d      = isa_iow_q;
    isa_data_out_d = isa_data_out_q;
    isa_data_oe_d  = isa_data_oe_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = ADDR;
          cmd_ready_d = 1'b0;
          write_d     = bus.cmd_write;
          wdata_d     = bus.cmd_wdata;
          isa_addr_d  = bus.cmd_addr;
          isa_ale_d   = 1'b1;
          isa_aen_d   = 1'b0;
        end
      end
      ADDR: begin
        state_d   = SETUP;
        isa_ale_d = 1'b0;
        if (write_q) begin
          isa_data_oe_d  = 1'b1;
          isa_data_out_d = wdata_q;
        end
      end
      SETUP: begin
        state_d     = STROBE;
        cnt_d       = 8'd0;
        wait_d      = 8'd0;
        timed_out_d = 1'b0;
        if (write_q) isa_iow_d = 1'b0;
        else         isa_ior_d = 1'b0;
      end
      STROBE: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // Past the minimum width, only CHRDY (or the optional timeout) ends the strobe.
        if (cnt_q >= STROBE_LAST) begin
          if (chrdy_s_q) begin
            state_d   = HOLD;
            isa_ior_d = 1'b1;
            isa_iow_d = 1'b1;
            if (!write_q) rsp_rdata_d = bus.isa_data_in;
          end else if (TIMEOUT_EN && (wait_q >= TIMEOUT_LIMIT)) begin
            state_d     = HOLD;
            isa_ior_d   = 1'b1;
            isa_iow_d   = 1'b1;
            timed_out_d = 1'b1;
            if (!write_q) rsp_rdata_d = 8'hFF;
          end else if (wait_q != 8'hFF) begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      HOLD: begin
        state_d       = RESP;
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = timed_out_q;
        isa_aen_d     = 1'b1;
        isa_data_oe_d = 1'b0;
      end
      RESP: begin
        state_d        = IDLE;
        rsp_valid_d    = 1'b0;
        rsp_timeout_d  = 1'b0;
        cmd_ready_d    = 1'b1;
        isa_addr_d     = 10'd0;
        isa_data_out_d = 8'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      wait_q         <= 8'd0;
      write_q        <= 1'b0;
      wdata_q        <= 8'd0;
      timed_out_q    <= 1'b0;
      chrdy_meta_q   <= 1'b1;
      chrdy_s_q      <= 1'b1;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 8'd0;
      rsp_timeout_q  <= 1'b0;
      isa_ale_q      <= 1'b0;
      isa_aen_q      <= 1'b1;
      isa_addr_q     <= 10'd0;
      isa_ior_q      <= 1'b1;
      isa_iow_q      <= 1'b1;
      isa_data_out_q <= 8'd0;
      isa_data_oe_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wait_q         <= wait_d;
      write_q        <= write_d;
      wdata_q        <= wdata_d;
      timed_out_q    <= timed_out_d;
      chrdy_meta_q   <= chrdy_meta_d;
      chrdy_s_q      <= chrdy_s_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_timeout_q  <= rsp_timeout_d;
      isa_ale_q      <= isa_ale_d;
      isa_aen_q      <= isa_aen_d;
      isa_addr_q     <= isa_addr_d;
      isa_ior_q      <= isa_ior_d;
      isa_iow_q      <= isa_iow_d;
      isa_data_out_q <= isa_data_out_d;
      isa_data_oe_q  <= isa_data_oe_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.isa_ale      = isa_ale_q;
  assign bus.isa_aen      = isa_aen_q;
  assign bus.isa_addr     = isa_addr_q;
  assign bus.isa_ior      = isa_ior_q;
  assign bus.isa_iow      = isa_iow_q;
  assign bus.isa_data_out = isa_data_out_q;
  assign bus.isa_data_oe  = isa_data_oe_q;

endmodule

// File: tb/tb_isa_io_cycle_initiator.sv
// Directed bench for isa_io_cycle_initiator: read, write, CHRDY waits, reset abort, back-to-back.
// With ISA_CHRDY_TIMEOUT_EN defined it also exercises the CHRDY timeout path.
module tb_isa_io_cycle_initiator;

  localparam int S = 4;
`ifdef ISA_CHRDY_TIMEOUT_EN
  localparam int TO        = 8;
  localparam int CHRDY_LOW = 4;
`else
  localparam int TO        = 64;
  localparam int CHRDY_LOW = 10;
`endif

  typedef struct {
    int         ale_first;
    int         ale_cnt;
    logic [9:0] ale_addr;
    int         ior_first;
    int         ior_cnt;
    int         iow_first;
    int         iow_cnt;
    int         oe_first;
    int         oe_cnt;
    logic       oe_data_ok;
    int         aen_low_cnt;
    int         rsp_cycle;
    int         rsp_cnt;
    logic [7:0] rdata;
    logic       tmo;
    int         ready_cycle;
  } obs_t;

  logic isa_clk = 1'b0;
  logic isa_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  isa_io_cycle_initiator_if bus ();

  isa_io_cycle_initiator #(
    .STROBE_CYCLES (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .isa_clk  (isa_clk),
    .isa_reset(isa_reset),
    .bus      (bus)
  );

  always #5 isa_clk = ~isa_clk;

  // Issues one command (handshake at edge 0) and records what the bus does per cycle.
  // CHRDY is driven low in cycles [lo_from, lo_from+lo_len); cycle k follows edge k-1.
  task automatic run_cmd(input logic wr, input logic [9:0] a, input logic [7:0] wd,
                         input int lo_from, input int lo_len, output obs_t o);
    o.ale_first = -1; o.ale_cnt = 0; o.ale_addr = '0;
    o.ior_first = -1; o.ior_cnt = 0; o.iow_first = -1; o.iow_cnt = 0;
    o.oe_first = -1; o.oe_cnt = 0; o.oe_data_ok = 1'b1; o.aen_low_cnt = 0;
    o.rsp_cycle = -1; o.rsp_cnt = 0; o.rdata = '0; o.tmo = 1'b0; o.ready_cycle = -1;
    bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    @(posedge isa_clk); #1;
    bus.cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bus.isa_chrdy = !(cyc >= lo_from && cyc < lo_from + lo_len);
      @(negedge isa_clk);
      if (bus.isa_ale === 1'b1) begin
        if (o.ale_first < 0) begin o.ale_first = cyc; o.ale_addr = bus.isa_addr; end
        o.ale_cnt++;
      end
      if (bus.isa_ior === 1'b0) begin if (o.ior_first < 0) o.ior_first = cyc; o.ior_cnt++; end
      if (bus.isa_iow === 1'b0) begin if (o.iow_first < 0) o.iow_first = cyc; o.iow_cnt++; end
      if (bus.isa_data_oe === 1'b1) begin
        if (o.oe_first < 0) o.oe_first = cyc;
        o.oe_cnt++;
        if (bus.isa_data_out !== wd) o.oe_data_ok = 1'b0;
      end
      if (bus.isa_aen === 1'b0) o.aen_low_cnt++;
      if (bus.rsp_valid === 1'b1) begin
        o.rsp_cnt++; o.rsp_cycle = cyc; o.rdata = bus.rsp_rdata; o.tmo = bus.rsp_timeout;
      end
      if (bus.cmd_ready === 1'b1) begin o.ready_cycle = cyc; break; end
      @(posedge isa_clk); #1;
    end
    @(posedge isa_clk); #1;
    bus.isa_chrdy = 1'b1;
  endtask

  task automatic test_reset();
    #1 isa_reset = 1'b1;
    #2;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 00", bus.rsp_rdata); end
    checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_timeout: got %b expected 0", bus.rsp_timeout); end
    checks++; if (bus.isa_ale !== 1'b0) begin errors++; $display("[TB] FAIL reset_ale: got %b expected 0", bus.isa_ale); end
    checks++; if (bus.isa_aen !== 1'b1) begin errors++; $display("[TB] FAIL reset_aen: got %b expected 1", bus.isa_aen); end
    checks++; if (bus.isa_addr !== 10'h000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 000", bus.isa_addr); end
    checks++; if (bus.isa_ior !== 1'b1) begin errors++; $display("[TB] FAIL reset_ior: got %b expected 1", bus.isa_ior); end
    checks++; if (bus.isa_iow !== 1'b1) begin errors++; $display("[TB] FAIL reset_iow: got %b expected 1", bus.isa_iow); end
    checks++; if (bus.isa_data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 00", bus.isa_data_out); end
    checks++; if (bus.isa_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_oe: got %b expected 0", bus.isa_data_oe); end
    repeat (3) @(posedge isa_clk);
    #1 isa_reset = 1'b0;
    repeat (2) @(posedge isa_clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_read();
    obs_t o;
    bus.isa_data_in = 8'h5C;
    run_cmd(1'b0, 10'h2A0, 8'h00, -1, 0, o);
    checks++; if (o.ale_first !== 1) begin errors++; $display("[TB] FAIL read_ale_cycle: got %0d expected 1", o.ale_first); end
    checks++; if (o.ale_cnt !== 1) begin errors++; $display("[TB] FAIL read_ale_len: got %0d expected 1", o.ale_cnt); end
    checks++; if (o.ale_addr !== 10'h2A0) begin errors++; $display("[TB] FAIL read_ale_addr: got %h expected 2a0", o.ale_addr); end
    checks++; if (o.ior_first !== 3) begin errors++; $display("[TB] FAIL read_ior_first: got %0d expected 3", o.ior_first); end
    checks++; if (o.ior_cnt !== S) begin errors++; $display("[TB] FAIL read_ior_len: got %0d expected %0d", o.ior_cnt, S); end
    checks++; if (o.iow_cnt !== 0) begin errors++; $display("[TB] FAIL read_iow_len: got %0d expected 0", o.iow_cnt); end
    checks++; if (o.oe_cnt !== 0) begin errors++; $display("[TB] FAIL read_oe_len: got %0d expected 0", o.oe_cnt); end
    checks++; if (o.aen_low_cnt !== 7) begin errors++; $display("[TB] FAIL read_aen_low: got %0d expected 7", o.aen_low_cnt); end
    checks++; if (o.rsp_cycle !== 8) begin errors++; $display("[TB] FAIL read_rsp_cycle: got %0d expected 8", o.rsp_cycle); end
    checks++; if (o.rsp_cnt !== 1) begin errors++; $display("[TB] FAIL read_rsp_count: got %0d expected 1", o.rsp_cnt); end
    checks++; if (o.rdata !== 8'h5C) begin errors++; $display("[TB] FAIL read_rdata: got %h expected 5c", o.rdata); end
    checks++; if (o.tmo !== 1'b0) begin errors++; $display("[TB] FAIL read_timeout: got %b expected 0", o.tmo); end
    checks++; if (o.ready_cycle !== 9) begin errors++; $display("[TB] FAIL read_ready_cycle: got %0d expected 9", o.ready_cycle); end
  endtask

  task automatic test_write();
    obs_t o;
    bus.isa_data_in = 8'h00;
    run_cmd(1'b1, 10'h2A1, 8'hA5, -1, 0, o);
    checks++; if (o.ale_addr !== 10'h2A1) begin errors++; $display("[TB] FAIL write_ale_addr: got %h expected 2a1", o.ale_addr); end
    checks++; if (o.oe_first !== 2) begin errors++; $display("[TB] FAIL write_oe_first: got %0d expected 2", o.oe_first); end
    checks++; if (o.oe_cnt !== 6) begin errors++; $display("[TB] FAIL write_oe_len: got %0d expected 6", o.oe_cnt); end
    checks++; if (o.oe_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL write_data_out: got ok=%b expected 1", o.oe_data_ok); end
    checks++; if (o.iow_first !== 3) begin errors++; $display("[TB] FAIL write_iow_first: got %0d expected 3", o.iow_first); end
    checks++; if (o.iow_cnt !== S) begin errors++; $display("[TB] FAIL write_iow_len: got %0d expected %0d", o.iow_cnt, S); end
    checks++; if (o.ior_cnt !== 0) begin errors++; $display("[TB] FAIL write_ior_len: got %0d expected 0", o.ior_cnt); end
    checks++; if (o.rsp_cycle !== 8) begin errors++; $display("[TB] FAIL write_rsp_cycle: got %0d expected 8", o.rsp_cycle); end
    checks++; if (o.rdata !== 8'h5C) begin errors++; $display("[TB] FAIL write_rdata_kept: got %h expected 5c", o.rdata); end
    checks++; if (bus.isa_data_out !== 8'h00) begin errors++; $display("[TB] FAIL write_idle_data: got %h expected 00", bus.isa_data_out); end
  endtask

  task automatic test_chrdy_wait();
    obs_t o;
    int   release_cycle;
    bus.isa_data_in = 8'h96;
    run_cmd(1'b0, 10'h0F3, 8'h00, 3, CHRDY_LOW, o);
    release_cycle = o.ior_first + o.ior_cnt;
    checks++; if (o.ior_first !== 3) begin errors++; $display("[TB] FAIL wait_ior_first: got %0d expected 3", o.ior_first); end
    checks++; if (o.ior_cnt < CHRDY_LOW + 2) begin errors++; $display("[TB] FAIL wait_ior_min: got %0d expected >= %0d", o.ior_cnt, CHRDY_LOW + 2); end
    checks++; if (release_cycle > 3 + CHRDY_LOW + 3) begin errors++; $display("[TB] FAIL wait_release: got cycle %0d expected <= %0d", release_cycle, 3 + CHRDY_LOW + 3); end
    checks++; if (o.rsp_cycle !== release_cycle + 1) begin errors++; $display("[TB] FAIL wait_rsp_cycle: got %0d expected %0d", o.rsp_cycle, release_cycle + 1); end
    checks++; if (o.rdata !== 8'h96) begin errors++; $display("[TB] FAIL wait_rdata: got %h expected 96", o.rdata); end
    checks++; if (o.tmo !== 1'b0) begin errors++; $display("[TB] FAIL wait_timeout: got %b expected 0", o.tmo); end
  endtask

`ifdef ISA_CHRDY_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    bus.isa_data_in = 8'h12;
    bus.isa_chrdy = 1'b0;
    repeat (3) @(posedge isa_clk);
    #1;
    run_cmd(1'b0, 10'h2A2, 8'h00, -100, 1000, o);
    checks++; if (o.ior_cnt !== S + TO) begin errors++; $display("[TB] FAIL tmo_ior_len: got %0d expected %0d", o.ior_cnt, S + TO); end
    checks++; if (o.rsp_cycle !== 4 + S + TO) begin errors++; $display("[TB] FAIL tmo_rsp_cycle: got %0d expected %0d", o.rsp_cycle, 4 + S + TO); end
    checks++; if (o.tmo !== 1'b1) begin errors++; $display("[TB] FAIL tmo_flag: got %b expected 1", o.tmo); end
    checks++; if (o.rdata !== 8'hFF) begin errors++; $display("[TB] FAIL tmo_rdata: got %h expected ff", o.rdata); end
    checks++; if (o.ready_cycle !== 5 + S + TO) begin errors++; $display("[TB] FAIL tmo_ready: got %0d expected %0d", o.ready_cycle, 5 + S + TO); end
  endtask
`endif

  task automatic test_reset_midcycle();
    obs_t o;
    int   rsp_seen = 0;
    bus.isa_data_in = 8'h00;
    bus.cmd_write = 1'b0; bus.cmd_addr = 10'h2A3; bus.cmd_valid = 1'b1;
    @(posedge isa_clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge isa_clk);
    @(negedge isa_clk);
    checks++; if (bus.isa_ior !== 1'b0) begin errors++; $display("[TB] FAIL abort_pre_strobe: got %b expected 0", bus.isa_ior); end
    isa_reset = 1'b1;
    #1;
    checks++; if (bus.isa_ior !== 1'b1) begin errors++; $display("[TB] FAIL abort_ior: got %b expected 1", bus.isa_ior); end
    checks++; if (bus.isa_aen !== 1'b1) begin errors++; $display("[TB] FAIL abort_aen: got %b expected 1", bus.isa_aen); end
    checks++; if (bus.isa_addr !== 10'h000) begin errors++; $display("[TB] FAIL abort_addr: got %h expected 000", bus.isa_addr); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 1", bus.cmd_ready); end
    @(posedge isa_clk); #1;
    isa_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge isa_clk);
      if (bus.rsp_valid === 1'b1) rsp_seen++;
    end
    checks++; if (rsp_seen !== 0) begin errors++; $display("[TB] FAIL abort_no_rsp: got %0d expected 0", rsp_seen); end
    @(posedge isa_clk); #1;
    bus.isa_data_in = 8'h3C;
    run_cmd(1'b0, 10'h155, 8'h00, -1, 0, o);
    checks++; if (o.ior_cnt !== S) begin errors++; $display("[TB] FAIL after_abort_ior: got %0d expected %0d", o.ior_cnt, S); end
    checks++; if (o.rsp_cycle !== 8) begin errors++; $display("[TB] FAIL after_abort_rsp: got %0d expected 8", o.rsp_cycle); end
    checks++; if (o.rdata !== 8'h3C) begin errors++; $display("[TB] FAIL after_abort_rdata: got %h expected 3c", o.rdata); end
  endtask

  task automatic test_back_to_back();
    int ale1 = -1, ale2 = -1, hs2 = -1, overlap = 0, last_ior = -1, first_iow = -1, rsp_cnt = 0;
    logic prev_ale = 1'b0;
    bus.isa_data_in = 8'h11;
    bus.cmd_write = 1'b0; bus.cmd_addr = 10'h300; bus.cmd_wdata = 8'h00; bus.cmd_valid = 1'b1;
    @(posedge isa_clk); #1;
    bus.cmd_write = 1'b1; bus.cmd_addr = 10'h301; bus.cmd_wdata = 8'h77;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge isa_clk);
      if (bus.isa_ale === 1'b1 && prev_ale === 1'b0) begin
        if (ale1 < 0) ale1 = cyc; else if (ale2 < 0) ale2 = cyc;
      end
      prev_ale = bus.isa_ale;
      if (bus.isa_ior === 1'b0 && bus.isa_iow === 1'b0) overlap++;
      if (bus.isa_ior === 1'b0) last_ior = cyc;
      if (bus.isa_iow === 1'b0 && first_iow < 0) first_iow = cyc;
      if (bus.rsp_valid === 1'b1) rsp_cnt++;
      if (bus.cmd_ready === 1'b1) begin
        if (hs2 < 0) hs2 = cyc;
        else break;
      end
      @(posedge isa_clk); #1;
      if (hs2 >= 0) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    @(posedge isa_clk); #1;
    checks++; if (hs2 !== 5 + S) begin errors++; $display("[TB] FAIL b2b_handshake_gap: got %0d expected %0d", hs2, 5 + S); end
    checks++; if (ale2 - ale1 !== 5 + S) begin errors++; $display("[TB] FAIL b2b_ale_gap: got %0d expected %0d", ale2 - ale1, 5 + S); end
    checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL b2b_overlap: got %0d expected 0", overlap); end
    checks++; if (!(last_ior > 0 && first_iow > last_ior)) begin errors++; $display("[TB] FAIL b2b_order: got ior_end=%0d iow_start=%0d expected iow after ior", last_ior, first_iow); end
    checks++; if (rsp_cnt !== 2) begin errors++; $display("[TB] FAIL b2b_rsp_count: got %0d expected 2", rsp_cnt); end
    checks++; if (bus.rsp_rdata !== 8'h11) begin errors++; $display("[TB] FAIL b2b_rdata: got %h expected 11", bus.rsp_rdata); end
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 10'h000;
    bus.cmd_wdata   = 8'h00;
    bus.isa_data_in = 8'h00;
    bus.isa_chrdy   = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_chrdy_wait();
`ifdef ISA_CHRDY_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midcycle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isa_io_cycle_initiator.md
# isa_io_cycle_initiator

ISA 8-bit I/O cycle initiator: converts a single-command request/response interface into a complete ISA I/O read or write bus cycle (ALE, AEN, SA[9:0], IOR#/IOW#, SD[7:0]), honouring CHRDY wait states from the addressed card. It is the host-side counterpart of the Sm2201 ISA–CAMAC interface board. It is used in the bench harness and in the host-emulation FPGA to exercise the board's register file without a PC.

## Interface
Parameters:
- STROBE_CYCLES, 4, minimum IOR#/IOW# low time in isa_clk cycles; legal range 1..255.
- TIMEOUT_CYCLES, 64, extra strobe cycles tolerated with CHRDY low before abort; legal range 1..255. Used only when timeout is compiled in.

Ports:
- isa_clk  in  1  bus clock; all logic on its rising edge.
- isa_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator idle and able to accept a command.
- cmd_write  in  1  1 = I/O write, 0 = I/O read.
- cmd_addr  in  10  I/O port address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse: cycle finished.
- rsp_rdata  out  8  read data, valid with rsp_valid.
- rsp_timeout  out  1  cycle aborted on CHRDY timeout, valid with rsp_valid.
- isa_ale  out  1  address latch enable.
- isa_aen  out  1  address enable; low during an initiator cycle.
- isa_addr  out  10  SA[9:0].
- isa_ior  out  1  IOR#, active low.
- isa_iow  out  1  IOW#, active low.
- isa_data_out  out  8  SD drive value.
- isa_data_oe  out  1  SD output enable for the external tristate.
- isa_data_in  in  8  SD sampled value.
- isa_chrdy  in  1  channel ready from the card; asynchronous.

## Operation
- Reset and idle values: cmd_ready=1, rsp_valid=0, rsp_rdata=0x00, rsp_timeout=0, isa_ale=0, isa_aen=1, isa_addr=0, isa_ior=1, isa_iow=1, isa_data_out=0x00, isa_data_oe=0.
- isa_chrdy passes through a 2-flop synchronizer (reset value 1) before use, giving chrdy_s.
- Handshake: a command is accepted when cmd_valid & cmd_ready at a clock edge. cmd_write, cmd_addr and cmd_wdata are latched at that edge. cmd_ready is 1 only in IDLE.
- FSM, one state per clock unless noted:
  - IDLE: wait for handshake, then go to ADDR.
  - ADDR: isa_ale=1, isa_aen=0, isa_addr=latched address.
  - SETUP: isa_ale=0. For writes, isa_data_oe=1 and isa_data_out=wdata.
  - STROBE: isa_ior=0 (read) or isa_iow=0 (write); an 8-bit counter runs from 0.
    - Exit to HOLD when count ≥ STROBE_CYCLES−1 and chrdy_s=1.
    - For reads, rsp_rdata is captured from isa_data_in on the exit edge.
  - HOLD: strobes high. Address, aen=0 and, for writes, data/oe are held.
  - RESP: rsp_valid=1. isa_aen=1, isa_data_oe=0, isa_addr keeps the last value. Next state is IDLE.
- rsp_rdata holds its value until the next read completes. Writes leave rsp_rdata unchanged.
- No backpressure on the response. No command queueing.
- Reset asserted mid-cycle: all outputs return immediately (asynchronously) to their idle values. The pending command is discarded and no rsp_valid is produced.

## Timing
- Handshake at edge 0:
  - ALE high in cycle 1.
  - Strobe low in cycles 3..2+S+W, where S=STROBE_CYCLES and W=wait cycles.
  - HOLD in cycle 3+S+W.
  - rsp_valid in cycle 4+S+W.
  - cmd_ready returns in cycle 5+S+W.
- With defaults and CHRDY high, rsp_valid is in cycle 8 and IOR#/IOW# is low for exactly 4 cycles.
- CHRDY low sampled at the board produces wait cycles W ≥ (low duration) + 2 synchronizer cycles, with the extension measured from the final minimum-strobe cycle.
- Back-to-back commands need a minimum of 5+S cycles between handshakes.

## Configuration
- ISA_CHRDY_TIMEOUT_EN defined:
  - In STROBE, when W reaches TIMEOUT_CYCLES with chrdy_s still 0, go to HOLD anyway.
  - That response has rsp_timeout=1, and for reads rsp_rdata=0xFF.
- ISA_CHRDY_TIMEOUT_EN undefined:
  - Strobe extends indefinitely while chrdy_s=0.
  - rsp_timeout is tied to 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Read, addr=0x2A0, isa_data_in=0x5C, CHRDY high: ALE pulse 1 cycle with isa_addr=0x2A0, IOR# low 4 cycles, IOW# stays 1, rsp_valid in cycle 8 with rsp_rdata=0x5C, rsp_timeout=0.
- Write, addr=0x2A1, wdata=0xA5: isa_data_oe=1 with data_out=0xA5 from SETUP through HOLD, IOW# low 4 cycles, rsp_valid in cycle 8, rsp_rdata unchanged.
- CHRDY driven low for 10 cycles from the first strobe cycle: IOR# low stretched to at least 12 cycles, release within 2 cycles after CHRDY rises, rsp_timeout=0.
- With ISA_CHRDY_TIMEOUT_EN, TIMEOUT_CYCLES=8, CHRDY held low: strobe low for 4+8 cycles, rsp_valid with rsp_timeout=1 and rsp_rdata=0xFF, cmd_ready back 1 cycle later.
- isa_reset pulsed during STROBE: IOR# high and isa_aen=1 without waiting for a clock edge, no rsp_valid, next command runs normally.
- cmd_valid held high with two commands queued by the bench: second ALE occurs exactly 5+S cycles after the first handshake, with no overlap of strobes.
